// File: rtl/pc_sequencer_if.sv
// Bus between the control/branch logic and the PC sequencer. The master side
// drives run/stall/branch/halt requests; the slave (pc_sequencer) returns the
// fetch address, run state and the cycle/instruction counters.
interface pc_sequencer_if #(
    parameter int PC_W  = 16,
    parameter int OFF_W = 8,
    parameter int CNT_W = 16
);
    logic             run_en;
    logic             stall;
    logic             branch;
    logic             branch_rel;
    logic [PC_W-1:0]  target;
    logic [OFF_W-1:0] offset;
    logic             halt_req;
    logic [PC_W-1:0]  PC;
    logic             fetch_valid;
    logic             haltProgram;
    logic             fault;
    logic [CNT_W-1:0] cycle_ct;
    logic [CNT_W-1:0] instr_ct;

    modport master (
        output run_en, stall, branch, branch_rel, target, offset, halt_req,
        input  PC, fetch_valid, haltProgram, fault, cycle_ct, instr_ct
    );

    modport slave (
        input  run_en, stall, branch, branch_rel, target, offset, halt_req,
        output PC, fetch_valid, haltProgram, fault, cycle_ct, instr_ct
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer for the 9-bit-ISA core: owns the PC, the
// run/halt state, stall handling, absolute/relative branch resolution and
// saturating cycle/instruction counters.
// Optional feature: define SEQ_BOUNDS_CHECK_EN to halt with a sticky fault
// when a retiring instruction would move the PC beyond MAX_PC.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | after reset; PC and counters held, waiting for run_en
// S_RUN    | fetching; PC advances on every non-stalled cycle
// S_HALTED | halt decoded (or bounds fault); frozen until start
module pc_sequencer #(
    parameter int          PC_W     = 16,
    parameter int          OFF_W    = 8,
    parameter int          CNT_W    = 16,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MAX_PC   = (1 << PC_W) - 1
) (
    input logic           CLK,
    input logic           start,
    pc_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    state_t           state_q, state_nxt;
    logic [PC_W-1:0]  pc_q, pc_nxt, pc_cand;
    logic [CNT_W-1:0] cyc_q, cyc_nxt;
    logic [CNT_W-1:0] ins_q, ins_nxt;
    logic             retire;

    // MAX_PC must be representable in the PC register.
    if (64'(MAX_PC) > ((64'd1 << PC_W) - 64'd1)) begin : g_bad_max_pc
        $error("pc_sequencer: MAX_PC does not fit in PC_W bits");
    end

    assign retire = (state_q == S_RUN) && !bus.stall;

    // Candidate next PC for a retiring instruction: branch target, relative
    // displacement (sign-extended, modulo 2**PC_W) or sequential increment.
    always_comb begin
        pc_cand = pc_q + PC_W'(1);
        if (bus.branch) begin
            if (bus.branch_rel) begin
                pc_cand = pc_q + PC_W'($signed(bus.offset));
            end else begin
                pc_cand = bus.target;
            end
        end
    end

`ifdef SEQ_BOUNDS_CHECK_EN
    logic fault_q, fault_nxt;
    logic out_of_bounds;

    assign out_of_bounds = 32'(pc_cand) > MAX_PC;
`endif

    // Next-state, PC and counter update logic.
    always_comb begin
        state_nxt = state_q;
        pc_nxt    = pc_q;
        cyc_nxt   = cyc_q;
        ins_nxt   = ins_q;
`ifdef SEQ_BOUNDS_CHECK_EN
        fault_nxt = fault_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.run_en) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Counters saturate rather than wrap.
                if (cyc_q != '1) begin
                    cyc_nxt = cyc_q + CNT_W'(1);
                end
                if (retire) begin
                    if (ins_q != '1) begin
                        ins_nxt = ins_q + CNT_W'(1);
                    end
                    // Halt wins over a branch decoded in the same cycle.
                    if (bus.halt_req) begin
                        state_nxt = S_HALTED;
`ifdef SEQ_BOUNDS_CHECK_EN
                    end else if (out_of_bounds) begin
                        fault_nxt = 1'b1;
                        state_nxt = S_HALTED;
`endif
                    end else begin
                        pc_nxt = pc_cand;
                    end
                end
            end
            S_HALTED: begin
                state_nxt = S_HALTED;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State, PC and counter registers; start aborts everything immediately.
    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            state_q <= S_IDLE;
            pc_q    <= PC_W'(RESET_PC);
            cyc_q   <= '0;
            ins_q   <= '0;
        end else begin
            state_q <= state_nxt;
            pc_q    <= pc_nxt;
            cyc_q   <= cyc_nxt;
            ins_q   <= ins_nxt;
        end
    end

`ifdef SEQ_BOUNDS_CHECK_EN
    // Sticky bounds fault, cleared only by start.
    always_ff @(posedge CLK or posedge start) begin
        if (start) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_nxt;
        end
    end

    assign bus.fault = fault_q;
`else
    assign bus.fault = 1'b0;
`endif

    assign bus.PC          = pc_q;
    assign bus.cycle_ct    = cyc_q;
    assign bus.instr_ct    = ins_q;
    assign bus.fetch_valid = (state_q == S_RUN);
    assign bus.haltProgram = (state_q == S_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: a table of directed vectors on a default-sized
// instance, plus hand-written sequences for counter saturation / PC wrap on a
// narrow instance and bounds checking / async reset on a MAX_PC=30 instance.
module tb_pc_sequencer;

    logic CLK;
    logic start;

    pc_sequencer_if #(.PC_W(16), .OFF_W(8), .CNT_W(16)) ifa ();
    pc_sequencer_if #(.PC_W(4),  .OFF_W(4), .CNT_W(4))  ifs ();
    pc_sequencer_if #(.PC_W(16), .OFF_W(8), .CNT_W(16)) ifc ();

    pc_sequencer #(.PC_W(16), .OFF_W(8), .CNT_W(16)) dut_a (
        .CLK(CLK), .start(start), .bus(ifa.slave)
    );
    pc_sequencer #(.PC_W(4), .OFF_W(4), .CNT_W(4)) dut_s (
        .CLK(CLK), .start(start), .bus(ifs.slave)
    );
    pc_sequencer #(.PC_W(16), .OFF_W(8), .CNT_W(16), .MAX_PC(30)) dut_c (
        .CLK(CLK), .start(start), .bus(ifc.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        run_en;
        logic        stall;
        logic        branch;
        logic        branch_rel;
        logic [15:0] target;
        logic [7:0]  offset;
        logic        halt_req;
        logic [15:0] exp_pc;
        logic [15:0] exp_cyc;
        logic [15:0] exp_ins;
        logic        exp_fv;
        logic        exp_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic re, input logic st, input logic br, input logic rel,
                       input logic [15:0] tgt, input logic [7:0] off, input logic hr,
                       input logic [15:0] pc, input logic [15:0] cyc, input logic [15:0] ins,
                       input logic fv, input logic hl);
        vec_t v;
        v.run_en = re; v.stall = st; v.branch = br; v.branch_rel = rel;
        v.target = tgt; v.offset = off; v.halt_req = hr;
        v.exp_pc = pc; v.exp_cyc = cyc; v.exp_ins = ins; v.exp_fv = fv; v.exp_halt = hl;
        vecs.push_back(v);
    endtask

    task automatic idle_inputs();
        ifa.run_en = 0; ifa.stall = 0; ifa.branch = 0; ifa.branch_rel = 0;
        ifa.target = '0; ifa.offset = '0; ifa.halt_req = 0;
        ifs.run_en = 0; ifs.stall = 0; ifs.branch = 0; ifs.branch_rel = 0;
        ifs.target = '0; ifs.offset = '0; ifs.halt_req = 0;
        ifc.run_en = 0; ifc.stall = 0; ifc.branch = 0; ifc.branch_rel = 0;
        ifc.target = '0; ifc.offset = '0; ifc.halt_req = 0;
    endtask

    initial begin
        //   re st br rel target   off    hr   pc        cyc  ins  fv hl
        add(0, 0, 1, 0, 16'd55,  8'h00, 1, 16'd0,     0,   0,  0, 0); // IDLE ignores all but run_en
        add(1, 0, 0, 0, 16'd0,   8'h00, 0, 16'd0,     0,   0,  1, 0);
        add(0, 0, 0, 0, 16'd0,   8'h00, 0, 16'd1,     1,   1,  1, 0);
        add(0, 0, 0, 0, 16'd0,   8'h00, 0, 16'd2,     2,   2,  1, 0);
        add(0, 0, 0, 0, 16'd0,   8'h00, 0, 16'd3,     3,   3,  1, 0);
        add(0, 0, 0, 0, 16'd0,   8'h00, 0, 16'd4,     4,   4,  1, 0);
        add(0, 0, 0, 0, 16'd0,   8'h00, 0, 16'd5,     5,   5,  1, 0);
        add(0, 0, 1, 0, 16'd10,  8'h00, 0, 16'd10,    6,   6,  1, 0);
        add(0, 0, 1, 1, 16'd0,   8'hFC, 0, 16'd6,     7,   7,  1, 0); // 10 - 4
        add(0, 0, 1, 1, 16'd0,   8'h05, 0, 16'd11,    8,   8,  1, 0); // 6 + 5
        add(0, 0, 1, 0, 16'd20,  8'h00, 0, 16'd20,    9,   9,  1, 0);
        add(0, 1, 1, 0, 16'd100, 8'h00, 0, 16'd20,   10,   9,  1, 0); // stall holds PC
        add(0, 1, 1, 0, 16'd100, 8'h00, 0, 16'd20,   11,   9,  1, 0);
        add(0, 1, 1, 0, 16'd100, 8'h00, 0, 16'd20,   12,   9,  1, 0);
        add(0, 0, 1, 0, 16'd100, 8'h00, 0, 16'd100,  13,  10,  1, 0);
        add(0, 1, 0, 0, 16'd0,   8'h00, 1, 16'd100,  14,  10,  1, 0); // stalled halt ignored
        add(0, 0, 1, 1, 16'd0,   8'h80, 0, 16'hFFE4, 15,  11,  1, 0); // 100 - 128 wraps
        add(0, 0, 1, 0, 16'd7,   8'h00, 0, 16'd7,    16,  12,  1, 0);
        add(0, 0, 1, 0, 16'd50,  8'h00, 1, 16'd7,    17,  13,  0, 1); // halt beats branch
        add(1, 0, 1, 0, 16'd50,  8'h00, 0, 16'd7,    17,  13,  0, 1); // frozen
        add(1, 0, 0, 0, 16'd0,   8'h00, 0, 16'd7,    17,  13,  0, 1);

        idle_inputs();
        start = 1'b1;
        #1;
        chk("reset_pc",    32'(ifa.PC), 32'd0);
        chk("reset_fv",    32'(ifa.fetch_valid), 32'd0);
        chk("reset_halt",  32'(ifa.haltProgram), 32'd0);
        chk("reset_fault", 32'(ifa.fault), 32'd0);
        chk("reset_cyc",   32'(ifa.cycle_ct), 32'd0);
        chk("reset_ins",   32'(ifa.instr_ct), 32'd0);
        step();
        step();
        start = 1'b0;

        // Main vector table on the default-sized instance.
        foreach (vecs[i]) begin
            ifa.run_en = vecs[i].run_en;   ifa.stall  = vecs[i].stall;
            ifa.branch = vecs[i].branch;   ifa.branch_rel = vecs[i].branch_rel;
            ifa.target = vecs[i].target;   ifa.offset = vecs[i].offset;
            ifa.halt_req = vecs[i].halt_req;
            step();
            chk($sformatf("v%0d_pc", i),    32'(ifa.PC),          32'(vecs[i].exp_pc));
            chk($sformatf("v%0d_cyc", i),   32'(ifa.cycle_ct),    32'(vecs[i].exp_cyc));
            chk($sformatf("v%0d_ins", i),   32'(ifa.instr_ct),    32'(vecs[i].exp_ins));
            chk($sformatf("v%0d_fv", i),    32'(ifa.fetch_valid), 32'(vecs[i].exp_fv));
            chk($sformatf("v%0d_halt", i),  32'(ifa.haltProgram), 32'(vecs[i].exp_halt));
            chk($sformatf("v%0d_fault", i), 32'(ifa.fault),       32'd0);
        end

        // Narrow instance: PC wraps 15 -> 0, counters saturate at 15.
        // Its run_en is the first time it leaves IDLE.
        idle_inputs();
        ifs.run_en = 1'b1;
        step();
        ifs.run_en = 1'b0;
        chk("narrow_start_pc", 32'(ifs.PC), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("narrow_pc_%0d", i),  32'(ifs.PC),       32'(i % 16));
            chk($sformatf("narrow_ins_%0d", i), 32'(ifs.instr_ct), 32'((i > 15) ? 15 : i));
            chk($sformatf("narrow_cyc_%0d", i), 32'(ifs.cycle_ct), 32'((i > 15) ? 15 : i));
        end

        // MAX_PC=30 instance: branch to 29 is legal, branch to 31 exceeds bound.
        ifc.run_en = 1'b1;
        step();
        ifc.run_en = 1'b0;
        ifc.branch = 1'b1;
        ifc.target = 16'd29;
        step();
        chk("bnd_pc29", 32'(ifc.PC), 32'd29);
        ifc.target = 16'd31;
        step();
        ifc.branch = 1'b0;
        chk("bnd_ins", 32'(ifc.instr_ct), 32'd2);
`ifdef SEQ_BOUNDS_CHECK_EN
        chk("bnd_pc",    32'(ifc.PC),          32'd29);
        chk("bnd_fault", 32'(ifc.fault),       32'd1);
        chk("bnd_halt",  32'(ifc.haltProgram), 32'd1);
        step();
        chk("bnd_fault_sticky", 32'(ifc.fault), 32'd1);
        chk("bnd_frozen_pc",    32'(ifc.PC),    32'd29);
`else
        chk("bnd_pc",    32'(ifc.PC),          32'd31);
        chk("bnd_fault", 32'(ifc.fault),       32'd0);
        chk("bnd_halt",  32'(ifc.haltProgram), 32'd0);
        step();
        chk("bnd_next_pc", 32'(ifc.PC), 32'd32);
`endif

        // Async start between edges resets every output at once.
        #2;
        start = 1'b1;
        #1;
        chk("async_pc",    32'(ifc.PC),          32'd0);
        chk("async_fv",    32'(ifc.fetch_valid), 32'd0);
        chk("async_halt",  32'(ifc.haltProgram), 32'd0);
        chk("async_fault", 32'(ifc.fault),       32'd0);
        chk("async_cyc",   32'(ifc.cycle_ct),    32'd0);
        chk("async_ins",   32'(ifc.instr_ct),    32'd0);
        chk("async_a_halt", 32'(ifa.haltProgram), 32'd0);
        chk("async_a_pc",   32'(ifa.PC),          32'd0);
        step();
        start = 1'b0;

        // After the start pulse the halted instance can run again.
        ifa.run_en = 1'b1;
        step();
        ifa.run_en = 1'b0;
        step();
        chk("restart_fv", 32'(ifa.fetch_valid), 32'd1);
        chk("restart_pc", 32'(ifa.PC),          32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
